// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver.
// Synchronises the asynchronous rxd line, finds the start bit, samples each bit
// at its centre and hands completed bytes to the consumer through a registered
// valid/ready port. Framing errors and dropped bytes are reported as sticky flags.

module uart_rx_core #(
  parameter int CLKS_PER_BIT = 1085,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rdata,
  output logic       rvalid,
  input  logic       rready,
  output logic       ferr,
  output logic       overrun,
  input  logic       clr_err
);

  // Counter wide enough for 0..CLKS_PER_BIT-1.
  localparam int CW = $clog2(CLKS_PER_BIT);

  // Last count of a full bit period, and the count that lands mid start bit.
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Synchroniser chain; stage 0 faces the pin, the top stage feeds the FSM.
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rxd_s;

  // Receiver state.
  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      shift;

  // One-cycle pulses from the FSM to the output stage.
  logic            byte_done;
  logic            frame_bad;

  assign rxd_s = sync_reg[SYNC_STAGES-1];

  // Synchroniser flops preset to idle-high so reset release never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], rxd};
    end
  end

  // Frame FSM: start detection, mid-bit sampling of data and stop bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      byte_done <= 1'b0;
      frame_bad <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      frame_bad <= 1'b0;
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rxd_s) begin
            state <= S_START;
          end
        end

        // Re-check the line half a bit in; a short low pulse is treated as noise.
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (rxd_s) begin
              state <= S_IDLE;
            end else begin
              state <= S_DATA;
              idx   <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // From here every sample point is a whole bit period after the previous one,
        // which keeps sampling at the centre of each bit.
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt        <= '0;
            shift[idx] <= rxd_s;
            if (idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // Returning to IDLE mid stop bit lets the next start edge be caught
        // even when frames arrive back to back.
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rxd_s) begin
              byte_done <= 1'b1;
              state     <= S_IDLE;
            end else begin
              frame_bad <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // A line held low (break) must not be mistaken for a stream of zero bytes.
        S_BREAK: begin
          cnt <= '0;
          if (rxd_s) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Output holding register and handshake; a byte arriving while the previous one
  // is still unclaimed is dropped rather than overwriting it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata  <= 8'h00;
      rvalid <= 1'b0;
    end else begin
      if (byte_done && (!rvalid || rready)) begin
        rdata  <= shift;
        rvalid <= 1'b1;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  // Sticky error flags; a new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ferr    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (frame_bad) begin
        ferr <= 1'b1;
      end else if (clr_err) begin
        ferr <= 1'b0;
      end

      if (byte_done && rvalid && !rready) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed and randomised frames against a queue-based
// model of which bytes and flags a UART receiver should produce.

module tb_uart_rx_core;

  localparam int C    = 16;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + C / 2 + 9 * C + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] rdata;
  logic       rvalid;
  logic       rready;
  logic       ferr;
  logic       overrun;
  logic       clr_err;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int rise_cyc  = -1;
  logic rv_prev = 1'b0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_rx_core #(
    .CLKS_PER_BIT(C),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rxd    (rxd),
    .rdata  (rdata),
    .rvalid (rvalid),
    .rready (rready),
    .ferr   (ferr),
    .overrun(overrun),
    .clr_err(clr_err)
  );

  always #4 clk = ~clk;

  // Cycle counter and log of every byte actually handed over (rvalid && rready at the edge).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && rvalid && rready) got_q.push_back(rdata);
  end

  // Timestamp of each rvalid rising edge, observed half a cycle after the clock.
  always @(negedge clk) begin
    if (rvalid && !rv_prev) rise_cyc <= cyc;
    rv_prev <= rvalid;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Serialise one 8N1 frame, LSB first, one bit per C clocks.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    start_cyc = cyc;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (C) @(negedge clk);
    end
    rxd = stop;
    repeat (C) @(negedge clk);
  endtask

  // Compare delivered bytes with the model's expectation, then start afresh.
  task automatic compare_q(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      $display("%s byte %0d: got 0x%02h expect 0x%02h", tag, i, got_q[i], exp_q[i]);
      check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int       lat;
    logic [7:0] b;
    logic     bad;
    logic     exp_ferr;

    rst = 1'b1; rxd = 1'b1; rready = 1'b1; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rvalid",  32'(rvalid),  0);
    check("reset_rdata",   32'(rdata),   0);
    check("reset_ferr",    32'(ferr),    0);
    check("reset_overrun", 32'(overrun), 0);
    rst = 1'b0;
    idle(20);
    check("post_reset_rvalid", 32'(rvalid), 0);

    // 1: single good frame, latency window.
    send_frame(8'h55, 1'b1);
    exp_q.push_back(8'h55);
    idle(10);
    lat = rise_cyc - start_cyc - 1;
    $display("t1 latency %0d cycles (nominal %0d)", lat, LAT);
    check("t1_latency_window", 32'(lat >= LAT - 1 && lat <= LAT + 1), 1);
    check("t1_ferr",    32'(ferr),    0);
    check("t1_overrun", 32'(overrun), 0);
    compare_q("t1");

    // 2: short glitch is rejected.
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle(200);
    check("t2_ferr",    32'(ferr),    0);
    check("t2_overrun", 32'(overrun), 0);
    compare_q("t2");

    // 3: bad stop bit, line held low, then a good frame.
    send_frame(8'hA3, 1'b0);
    repeat (40) @(negedge clk);
    idle(10);
    check("t3_ferr_set", 32'(ferr), 1);
    send_frame(8'h3C, 1'b1);
    exp_q.push_back(8'h3C);
    idle(10);
    compare_q("t3");
    check("t3_rdata", 32'(rdata), 32'h3C);
    pulse_clr();
    check("t3_ferr_clr", 32'(ferr), 0);

    // 4: consumer stalled, second byte overruns.
    rready = 1'b0;
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    idle(10);
    check("t4_rvalid_held", 32'(rvalid),  1);
    check("t4_rdata_held",  32'(rdata),   32'h01);
    check("t4_overrun",     32'(overrun), 1);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("t4_rvalid_drop", 32'(rvalid), 0);
    exp_q.push_back(8'h01);
    compare_q("t4");
    pulse_clr();
    check("t4_overrun_clr", 32'(overrun), 0);
    rready = 1'b1;
    idle(5);

    // 5: back-to-back frames, no idle gap.
    send_frame(8'hFF, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'h80, 1'b1);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h80);
    idle(10);
    compare_q("t5");
    check("t5_ferr",    32'(ferr),    0);
    check("t5_overrun", 32'(overrun), 0);

    // 6: reset during data bit 3 of 0x5A.
    b = 8'h5A;
    rxd = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rxd = b[i];
      repeat (C) @(negedge clk);
    end
    rxd = b[3];
    repeat (C / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_rst_rvalid",  32'(rvalid),  0);
    check("t6_rst_rdata",   32'(rdata),   0);
    check("t6_rst_ferr",    32'(ferr),    0);
    check("t6_rst_overrun", 32'(overrun), 0);
    rxd = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(20);
    send_frame(8'hC6, 1'b1);
    exp_q.push_back(8'hC6);
    idle(10);
    compare_q("t6");
    check("t6_rdata", 32'(rdata), 32'hC6);

    // Random frames: random payload, occasional bad stop bit, random gaps.
    exp_ferr = 1'b0;
    for (int k = 0; k < 20; k++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      send_frame(b, !bad);
      if (bad) begin
        repeat (40) @(negedge clk);
        idle(4);
        exp_ferr = 1'b1;
      end else begin
        exp_q.push_back(b);
      end
      idle($urandom_range(0, 12));
    end
    idle(20);
    compare_q("rand");
    check("rand_ferr",    32'(ferr),    32'(exp_ferr));
    check("rand_overrun", 32'(overrun), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
